// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: shared state encoding, parity modes and baud divider math  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_tick_div(input int clk_hz, input int bit_rate,
                                       input int oversample);
    return clk_hz / (bit_rate * oversample);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +----------------------------------------------------------------------+
// | uart_baud_tick: one-cycle oversampling tick every TICK_DIV clocks    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 1) begin : g_div_check
    $error("uart_baud_tick: clock too slow for BIT_RATE*OVERSAMPLE");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// +----------------------------------------------------------------------+
// | uart_rx_os: oversampling UART receiver, majority vote, parity/stop   |
// | checks and a one-entry valid/ready holding register. Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_parity_err,
  output logic                    rx_frame_err,
  output logic                    rx_break,
  output logic                    rx_overrun,
  output logic                    rx_busy
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(PAYLOAD_BITS);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PAYLOAD_BITS < 5 ||
      PAYLOAD_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_os: illegal parameter combination");
  end

  rx_state_t               state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [SW-1:0]           s_q, s_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [1:0]              vote_q, vote_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    par_err_q, par_err_d;
  logic                    frame_err_q, frame_err_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
  logic                    ovr_q, ovr_d, busy_q, busy_d;

  logic rxd_s, tick, start_det, frame_done, wrap, vote_pt, voted;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BIT_RATE  (BIT_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(start_det),
    .tick (tick)
  );

  assign rxd_s   = sync_q[1];
  assign wrap    = tick && (s_q == SW'(OVERSAMPLE - 1));
  assign vote_pt = tick && (s_q == SW'(HALF + 1));
  assign voted   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], uart_rxd};
    s_d         = s_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    data_d      = data_q;
    valid_d     = valid_q;
    pe_d        = pe_q;
    fe_d        = fe_q;
    brk_d       = brk_q;
    ovr_d       = 1'b0;
    start_det   = 1'b0;
    frame_done  = 1'b0;

    if (tick && state_q != ST_IDLE) begin
      s_d = wrap ? '0 : s_q + SW'(1);
      if (s_q == SW'(HALF - 1)) vote_d[0] = rxd_s;
      if (s_q == SW'(HALF))     vote_d[1] = rxd_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (uart_rx_en && !rxd_s) begin
          start_det   = 1'b1;
          state_d     = ST_START;
          s_d         = '0;
          bit_cnt_d   = '0;
          stop_cnt_d  = 1'b0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (vote_pt && voted) begin
          state_d = ST_IDLE;
          s_d     = '0;
        end else if (wrap) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (vote_pt) shift_d = {voted, shift_q[PAYLOAD_BITS-1:1]};
        if (wrap) begin
          if (bit_cnt_q == BW'(PAYLOAD_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (vote_pt) par_err_d = (^shift_q) ^ voted ^ (PARITY == PAR_ODD);
        if (wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (vote_pt) begin
          frame_err_d = frame_err_q | ~voted;
          // Ending at the final vote point leaves half a bit to catch the next start edge.
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d    = ST_IDLE;
            s_d        = '0;
            frame_done = 1'b1;
          end
        end else if (wrap) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        pe_d    = par_err_q;
        fe_d    = frame_err_d;
        brk_d   = frame_err_d && (shift_q == '0);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      s_q         <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      vote_q      <= 2'b11;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      brk_q       <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      s_q         <= s_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      brk_q       <= brk_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = pe_q;
  assign rx_frame_err  = fe_q;
  assign rx_break      = brk_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = busy_q;

endmodule

`default_nettype wire
